// File: rtl/bit_timer.sv
// bit_timer: segmented bit-period timer.
//
// A bit period is split into NSEG segments whose lengths come from seg_len.
// While running, count_out counts 1..L inside the current segment. At the end
// of each segment seg_strobe pulses and seg_idx advances. At the end of the
// last segment period_done pulses and bit_count advances. At the end of the
// last bit of a frame frame_done pulses, and the timer either stops
// (oneshot=1) or carries on with the next frame.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   start        IDLE -> RUN request (ignored while running)
//   enable       advance qualifier while running
//   clear        synchronous return to IDLE
//   resync       phase realignment pulse (RUN only)
//   oneshot      1 = stop after one frame, 0 = continuous
//   seg_len      segment lengths, segment i at [i*CNT_W +: CNT_W] (0 acts as 1)
//   resync_load  count loaded on resync (0 acts as 1)
//   frame_bits   bits per frame (0 acts as 1)
//   count_out    registered in-segment count
//   seg_idx      registered segment index
//   bit_count    registered completed-bit count within the frame
//   seg_strobe, period_done, frame_done, busy   decoded status
module bit_timer #(
  parameter int CNT_W = 5,
  parameter int NSEG  = 3,
  parameter int BIT_W = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     enable,
  input  logic                                     clear,
  input  logic                                     resync,
  input  logic                                     oneshot,
  input  logic [NSEG*CNT_W-1:0]                    seg_len,
  input  logic [CNT_W-1:0]                         resync_load,
  input  logic [BIT_W-1:0]                         frame_bits,
  output logic [CNT_W-1:0]                         count_out,
  output logic [((NSEG > 1) ? $clog2(NSEG) : 1)-1:0] seg_idx,
  output logic [BIT_W-1:0]                         bit_count,
  output logic                                     seg_strobe,
  output logic                                     period_done,
  output logic                                     frame_done,
  output logic                                     busy
);

  localparam int SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [SEG_W-1:0] SEG_ZERO = {SEG_W{1'b0}};
  localparam logic [SEG_W-1:0] SEG_ONE  = SEG_W'(1'b1);
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NSEG - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1'b1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [SEG_W-1:0]   seg_r;
  logic [SEG_W-1:0]   seg_nxt_s;
  logic [BIT_W-1:0]   bit_r;
  logic [BIT_W-1:0]   bit_nxt_s;

  logic [CNT_W-1:0]   len_raw_s;
  logic [CNT_W-1:0]   len_s;
  logic [CNT_W-1:0]   load_s;
  logic [BIT_W-1:0]   frame_len_s;
  logic               run_s;
  logic               term_s;
  logic               strobe_s;
  logic               last_seg_s;
  logic               last_bit_s;

  // Current segment length and the terminal/strobe decode.
  always_comb begin
    len_raw_s = CNT_ZERO;
    // OR-mux over the valid segments only; seg_r never exceeds NSEG-1.
    for (int i = 0; i < NSEG; i++) begin
      len_raw_s = len_raw_s | ((seg_r == SEG_W'(i)) ? seg_len[i*CNT_W +: CNT_W] : CNT_ZERO);
    end
    len_s       = (len_raw_s == CNT_ZERO) ? CNT_ONE : len_raw_s;
    load_s      = (resync_load == CNT_ZERO) ? CNT_ONE : resync_load;
    frame_len_s = (frame_bits == BIT_ZERO) ? BIT_ONE : frame_bits;
    run_s       = (state_r == RUN);
    last_seg_s  = (seg_r == SEG_LAST);
    last_bit_s  = (bit_r == (frame_len_s - BIT_ONE));
    // ">=" so a length shortened below the running count ends the segment.
    term_s      = run_s & enable & (cnt_r >= len_s);
    // Higher-priority controls in the same cycle suppress every strobe.
    strobe_s    = term_s & ~rst & ~clear & ~resync;
  end

  // Next-state, counter and segment/bit sequencing.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    seg_nxt_s   = seg_r;
    bit_nxt_s   = bit_r;
    if (clear) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = CNT_ZERO;
      seg_nxt_s   = SEG_ZERO;
      bit_nxt_s   = BIT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_nxt_s = CNT_ZERO;
          seg_nxt_s = SEG_ZERO;
          bit_nxt_s = BIT_ZERO;
          if (start) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = CNT_ONE;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN: begin
          if (resync) begin
            cnt_nxt_s = load_s;
            seg_nxt_s = SEG_ZERO;
          end else if (!enable) begin
            cnt_nxt_s = cnt_r;
          end else if (term_s) begin
            cnt_nxt_s = CNT_ONE;
            seg_nxt_s = last_seg_s ? SEG_ZERO : (seg_r + SEG_ONE);
            if (last_seg_s) begin
              if (last_bit_s) begin
                bit_nxt_s = BIT_ZERO;
                if (oneshot) begin
                  state_nxt_s = IDLE;
                  cnt_nxt_s   = CNT_ZERO;
                  seg_nxt_s   = SEG_ZERO;
                end else begin
                  state_nxt_s = RUN;
                end
              end else begin
                bit_nxt_s = bit_r + BIT_ONE;
              end
            end else begin
              bit_nxt_s = bit_r;
            end
          end else begin
            // cnt_r < len_s here, so this never overflows the counter.
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
          seg_nxt_s   = SEG_ZERO;
          bit_nxt_s   = BIT_ZERO;
        end
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      seg_r   <= SEG_ZERO;
      bit_r   <= BIT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      seg_r   <= seg_nxt_s;
      bit_r   <= bit_nxt_s;
    end
  end

  assign count_out   = cnt_r;
  assign seg_idx     = seg_r;
  assign bit_count   = bit_r;
  assign seg_strobe  = strobe_s;
  assign period_done = strobe_s & last_seg_s;
  assign frame_done  = strobe_s & last_seg_s & last_bit_s;
  assign busy        = run_s & ~rst;

endmodule

// File: tb/tb_bit_timer.sv
// Directed testbench for bit_timer with a scoreboard queue of expected
// output vectors {count_out, seg_idx, bit_count, seg_strobe, period_done,
// frame_done, busy}.
module tb_bit_timer;

  localparam int CNT_W = 5;
  localparam int NSEG  = 3;
  localparam int BIT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   enable;
  logic                   clear;
  logic                   resync;
  logic                   oneshot;
  logic [NSEG*CNT_W-1:0]  seg_len;
  logic [CNT_W-1:0]       resync_load;
  logic [BIT_W-1:0]       frame_bits;
  logic [CNT_W-1:0]       count_out;
  logic [1:0]             seg_idx;
  logic [BIT_W-1:0]       bit_count;
  logic                   seg_strobe;
  logic                   period_done;
  logic                   frame_done;
  logic                   busy;

  logic [14:0]            obs;
  logic [14:0]            last_obs;
  string                  tag_q[$];
  logic [14:0]            exp_q[$];
  int                     checks = 0;
  int                     errors = 0;
  int                     pd_cnt;

  always #5 clk = ~clk;

  bit_timer #(.CNT_W(CNT_W), .NSEG(NSEG), .BIT_W(BIT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .clear(clear),
    .resync(resync), .oneshot(oneshot), .seg_len(seg_len),
    .resync_load(resync_load), .frame_bits(frame_bits),
    .count_out(count_out), .seg_idx(seg_idx), .bit_count(bit_count),
    .seg_strobe(seg_strobe), .period_done(period_done),
    .frame_done(frame_done), .busy(busy)
  );

  assign obs = {count_out, seg_idx, bit_count, seg_strobe, period_done, frame_done, busy};

  function automatic logic [14:0] mk(int c, int s, int b, int ss, int pd, int fd, int bz);
    return {5'(c), 2'(s), 4'(b), 1'(ss), 1'(pd), 1'(fd), 1'(bz)};
  endfunction

  // Free-running pattern for lengths 8,8,9: period of 25 cycles, cycle 1 = first RUN cycle.
  function automatic logic [14:0] model_a(int k);
    int p, s, c;
    p = (k - 1) % 25 + 1;
    if (p <= 8) begin s = 0; c = p; end
    else if (p <= 16) begin s = 1; c = p - 8; end
    else begin s = 2; c = p - 16; end
    return mk(c, s, (k - 1) / 25, int'(p == 8 || p == 16 || p == 25), int'(p == 25), 0, 1);
  endfunction

  // Oneshot frame of 3 bits with lengths 2,2,2: 18 running cycles, then IDLE.
  function automatic logic [14:0] model_b(int k);
    int p;
    if (k > 18) return mk(0, 0, 0, 0, 0, 0, 0);
    p = (k - 1) % 6 + 1;
    return mk((p - 1) % 2 + 1, (p - 1) / 2, (k - 1) / 6, int'(p % 2 == 0), int'(p == 6),
              int'(p == 6 && (k - 1) / 6 == 2), 1);
  endfunction

  task automatic pop_check();
    string t;
    logic [14:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %h required an expected entry", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      last_obs = obs;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  // Inputs for the current cycle are already driven; check, then cross one edge.
  task automatic step(input string t, input logic [14:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
    #1;
    pop_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; enable = 1'b0; clear = 1'b0; resync = 1'b0;
    oneshot = 1'b0; seg_len = {5'd9, 5'd8, 5'd8}; resync_load = 5'd0;
    frame_bits = 4'd10;
    @(posedge clk);
    #1;
    step("reset", mk(0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    // Basic period: strobes at 8, 16, 25, repeating every 25 cycles.
    start = 1'b1; enable = 1'b1;
    step("idle_start", mk(0, 0, 0, 0, 0, 0, 0));
    start = 1'b0;
    for (int k = 1; k <= 50; k++) step("period", model_a(k));
    clear = 1'b1;
    step("clear_run", model_a(51));
    clear = 1'b0;

    // resync in IDLE is ignored.
    resync = 1'b1; resync_load = 5'd5;
    step("idle_resync", mk(0, 0, 0, 0, 0, 0, 0));
    resync = 1'b0;
    step("idle_hold", mk(0, 0, 0, 0, 0, 0, 0));

    // Oneshot frame of 3 bits.
    seg_len = {5'd2, 5'd2, 5'd2}; frame_bits = 4'd3; oneshot = 1'b1; start = 1'b1;
    step("start_oneshot", mk(0, 0, 0, 0, 0, 0, 0));
    start = 1'b0;
    pd_cnt = 0;
    for (int k = 1; k <= 19; k++) begin
      step("oneshot", model_b(k));
      pd_cnt += int'(last_obs[2]);
    end
    checks++;
    assert (pd_cnt == 3) else begin
      errors++;
      $error("FAIL pd_count: observed %0d expected %0d", pd_cnt, 3);
    end

    // enable toggling: enabled on even cycles only, first strobe at 16.
    seg_len = {5'd9, 5'd8, 5'd8}; frame_bits = 4'd10; oneshot = 1'b0;
    start = 1'b1; enable = 1'b0;
    step("start_toggle", mk(0, 0, 0, 0, 0, 0, 0));
    start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      enable = (k % 2 == 0);
      step("toggle", mk((k == 17) ? 1 : ((k % 2 == 1) ? (k + 1) / 2 : k / 2),
                        int'(k == 17), 0, int'(k == 16), 0, 0, 1));
    end
    clear = 1'b1; enable = 1'b1;
    step("clear_toggle", mk(1, 1, 0, 0, 0, 0, 1));
    clear = 1'b0;

    // resync at count 3 in seg1 during the second bit.
    start = 1'b1;
    step("start_resync", mk(0, 0, 0, 0, 0, 0, 0));
    start = 1'b0;
    for (int k = 1; k <= 35; k++) step("pre_resync", model_a(k));
    resync = 1'b1; resync_load = 5'd5;
    step("resync_at3", model_a(36));
    resync = 1'b0;
    step("resync_load5", mk(5, 0, 1, 0, 0, 0, 1));
    step("resync_6", mk(6, 0, 1, 0, 0, 0, 1));
    step("resync_7", mk(7, 0, 1, 0, 0, 0, 1));
    // T cycle with a resync of load 0: strobe suppressed, count loads 1, seg stays 0.
    resync = 1'b1; resync_load = 5'd0;
    step("resync_supp", mk(8, 0, 1, 0, 0, 0, 1));
    resync = 1'b0;
    for (int j = 1; j <= 7; j++) step("post_resync", mk(j, 0, 1, 0, 0, 0, 1));
    clear = 1'b1; resync = 1'b1;
    step("clr_rsy_T", mk(8, 0, 1, 0, 0, 0, 1));
    clear = 1'b0; resync = 1'b0;
    step("after_clear", mk(0, 0, 0, 0, 0, 0, 0));

    // Reset colliding with every other control on a terminal cycle.
    start = 1'b1;
    step("start_rst", mk(0, 0, 0, 0, 0, 0, 0));
    start = 1'b0;
    for (int k = 1; k <= 7; k++) step("pre_rst", mk(k, 0, 0, 0, 0, 0, 1));
    rst = 1'b1; clear = 1'b1; resync = 1'b1; start = 1'b1;
    step("rst_T", mk(8, 0, 0, 0, 0, 0, 0));
    step("rst_hold", mk(0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0; clear = 1'b0; resync = 1'b0; start = 1'b0;
    step("post_rst", mk(0, 0, 0, 0, 0, 0, 0));

    // Length reduced mid-segment, then zero-length segment 0.
    start = 1'b1;
    step("start_len", mk(0, 0, 0, 0, 0, 0, 0));
    start = 1'b0;
    for (int k = 1; k <= 5; k++) step("pre_len", mk(k, 0, 0, 0, 0, 0, 1));
    enable = 1'b0; seg_len = {5'd9, 5'd8, 5'd3};
    step("len_cut_dis", mk(6, 0, 0, 0, 0, 0, 1));
    enable = 1'b1;
    step("len_cut_T", mk(6, 0, 0, 1, 0, 0, 1));
    step("len_cut_next", mk(1, 1, 0, 0, 0, 0, 1));
    seg_len = {5'd2, 5'd2, 5'd0};
    step("len2_seg1", mk(2, 1, 0, 1, 0, 0, 1));
    step("len2_seg2a", mk(1, 2, 0, 0, 0, 0, 1));
    step("len2_seg2b", mk(2, 2, 0, 1, 1, 0, 1));
    step("len0_seg0", mk(1, 0, 1, 1, 0, 0, 1));
    start = 1'b1;
    step("start_in_run", mk(1, 1, 1, 0, 0, 0, 1));
    start = 1'b0;
    step("start_ignored", mk(2, 1, 1, 1, 0, 0, 1));
    step("wrap_seg2", mk(1, 2, 1, 0, 0, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_timer.md
BIT_TIMER -- requirements
Module: bit_timer

Interface
REQ-001 SHALL provide parameter CNT_W, default 5, width of the in-segment counter.
REQ-002 SHALL provide parameter NSEG, default 3, number of segments per bit period (>=1).
REQ-003 SHALL provide parameter BIT_W, default 4, width of the bit counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port start  input  1  IDLE->RUN request.
REQ-007 SHALL have port enable  input  1  advance qualifier while in RUN.
REQ-008 SHALL have port clear  input  1  synchronous return to IDLE.
REQ-009 SHALL have port resync  input  1  phase realignment pulse.
REQ-010 SHALL have port oneshot  input  1  1 = stop after one frame, 0 = continuous.
REQ-011 SHALL have port seg_len  input  NSEG*CNT_W  segment lengths, segment i at bits [i*CNT_W +: CNT_W].
REQ-012 SHALL have port resync_load  input  CNT_W  count value loaded on resync.
REQ-013 SHALL have port frame_bits  input  BIT_W  bits per frame.
REQ-014 SHALL have port count_out  output  CNT_W  registered in-segment count.
REQ-015 SHALL have port seg_idx  output  max(1,$clog2(NSEG))  registered current segment index.
REQ-016 SHALL have port bit_count  output  BIT_W  registered completed-bit count within frame.
REQ-017 SHALL have ports seg_strobe, period_done, frame_done, busy  output  1 each  decoded status.

Function
REQ-018 SHALL implement two states, IDLE and RUN; busy = (state == RUN).
REQ-019 IDLE SHALL hold count_out=0, seg_idx=0, bit_count=0; start=1 SHALL move to RUN with count_out=1 next cycle.
REQ-020 In RUN with enable=0, all registers SHALL hold and all strobes SHALL be 0.
REQ-021 Effective length L = seg_len[seg_idx], with 0 treated as 1.
REQ-022 Terminal condition T = RUN & enable & (count_out >= L); ">=" covers a length reduced mid-segment.
REQ-023 In RUN with enable=1 and not T, count_out SHALL increment by 1.
REQ-024 On T, seg_strobe SHALL be 1 that cycle (combinational decode of registered state and inputs), count_out SHALL load 1, and seg_idx SHALL advance, wrapping NSEG-1 -> 0.
REQ-025 period_done SHALL be 1 on T with seg_idx == NSEG-1; bit_count SHALL then increment.
REQ-026 frame_done SHALL be 1 on period_done with bit_count == frame_bits-1 (frame_bits=0 treated as 1); bit_count SHALL then load 0.
REQ-027 On frame_done with oneshot=1, next state SHALL be IDLE with all counters 0; with oneshot=0, RUN continues.
REQ-028 resync in RUN SHALL load count_out=resync_load (0 loads 1) and seg_idx=0, keep bit_count, and suppress all strobes that cycle.
REQ-029 resync in IDLE SHALL be ignored.
REQ-030 clear SHALL force IDLE and zero all counters next cycle, from any state.
REQ-031 Priority SHALL be rst > clear > resync > start/terminal/increment; start in RUN SHALL be ignored.
REQ-032 seg_len, frame_bits and oneshot SHALL be sampled every cycle; there is no shadow register.
REQ-033 count_out SHALL never exceed 2^CNT_W-1; there is no arithmetic wrap beyond L.

Reset
REQ-034 rst=1 at a rising edge SHALL set state=IDLE, count_out=0, seg_idx=0, bit_count=0; all decoded outputs SHALL be 0 while in reset.
REQ-035 rst asserted mid-RUN SHALL take effect at that edge regardless of enable, clear, resync or start.

Verification
REQ-036 seg_len={9,8,8} (seg0=8, seg1=8, seg2=9), enable=1, start pulse -> seg_strobe at cumulative cycles 8, 16, 25; period_done at 25; pattern repeats every 25 cycles.
REQ-037 frame_bits=3, oneshot=1 -> exactly 3 period_done pulses; frame_done coincides with the 3rd; busy drops the next cycle.
REQ-038 enable toggling 1/0 every cycle -> first seg_strobe after 16 cycles with default lengths; no strobe on any enable=0 cycle.
REQ-039 resync with resync_load=5 at count_out=3 in seg1 -> next count_out=5, seg_idx=0; seg_strobe 4 cycles later; bit_count unchanged.
REQ-040 Simultaneous clear+resync+T -> IDLE, counters 0, no strobe; rst during the same cycle -> identical reset state.
REQ-041 seg_len[seg0] changed from 8 to 3 while count_out=6 -> T on the next enabled cycle; seg_len[seg0]=0 -> strobe every enabled cycle in seg0.
